ram_writer_serial: RTL and testbench

- Serial-to-RAM receiver at the far end of the matrix-display byte link.
- Samples the sclk/sda bit stream produced by the serial RAM reader on the sending side.
- Reassembles bytes and writes them sequentially into a local frame RAM through a single-cycle write strobe.
- Recovers bit alignment after link stalls with an idle timeout, and flags framing errors.

---
 rtl/ram_writer_serial_if.sv | 23 ++
 rtl/ram_writer_serial.sv | 103 ++++++++++
 tb/tb_ram_writer_serial.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_writer_serial_if.sv
// Serial byte link plus local frame-RAM write port seen by ram_writer_serial.
// The master side drives sclk/sda; the slave side receives bytes and writes RAM.
interface ram_writer_serial_if #(
   parameter int ADDR_W = 16
);
   logic              sclk;
   logic              sda;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic              ram_we;
   logic              frame_done;
   logic              gap_err;

   modport master (
      output sclk, sda,
      input  ram_addr, ram_data, ram_we, frame_done, gap_err
   );

   modport slave (
      input  sclk, sda,
      output ram_addr, ram_data, ram_we, frame_done, gap_err
   );
endinterface

// File: rtl/ram_writer_serial.sv
// Receives LSB-first bytes (8 data slots + one zero gap slot) from the serial
// link and writes them sequentially into the frame RAM, wrapping at DEPTH.
module ram_writer_serial #(
   parameter int ADDR_W       = 16,
   parameter int DEPTH        = 8192,
   parameter int IDLE_TIMEOUT = 4096
) (
   input logic               clk,
   input logic               reset,
   ram_writer_serial_if.slave bus
);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   // sclk_sync[1] is the synchronized sclk, sclk_sync[2] its previous value
   logic [2:0]        sclk_sync;
   logic [1:0]        sda_sync;
   logic              sclk_fall;
   logic              sclk_edge;
   logic              fall_q;
   logic              sda_q;
   logic [3:0]        bit_cnt;
   logic [7:0]        shift;
   logic [ADDR_W-1:0] wr_ptr;
   logic [TW-1:0]     idle_cnt;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [7:0]        ram_data_q;
   logic              ram_we_q;
   logic              frame_done_q;
   logic              gap_err_q;

   assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
   assign sclk_edge = sclk_sync[2] ^ sclk_sync[1];

   // The fall event and its data bit are registered together, giving the
   // edge stage between the synchronizers and the output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync <= 3'b000;
         sda_sync  <= 2'b00;
         fall_q    <= 1'b0;
         sda_q     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], bus.sclk};
         sda_sync  <= {sda_sync[0], bus.sda};
         fall_q    <= sclk_fall;
         sda_q     <= sda_sync[1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
      end else if (sclk_edge) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TW'(IDLE_TIMEOUT)) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   // A saturated idle timer realigns to slot 0; it is always 0 while fall_q
   // is set, so a sampled bit never races a realignment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt      <= 4'd0;
         shift        <= 8'h00;
         wr_ptr       <= '0;
         ram_addr_q   <= '0;
         ram_data_q   <= 8'h00;
         ram_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         gap_err_q    <= 1'b0;
      end else begin
         ram_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         gap_err_q    <= 1'b0;
         if (fall_q) begin
            if (bit_cnt != 4'd8) begin
               shift[bit_cnt[2:0]] <= sda_q;
               bit_cnt             <= bit_cnt + 4'd1;
            end else if (!sda_q) begin
               ram_data_q   <= shift;
               ram_addr_q   <= wr_ptr;
               ram_we_q     <= 1'b1;
               frame_done_q <= (wr_ptr == ADDR_W'(DEPTH - 1));
               wr_ptr       <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
               bit_cnt      <= 4'd0;
            end else begin
               gap_err_q <= 1'b1;
               bit_cnt   <= 4'd0;
            end
         end else if (idle_cnt == TW'(IDLE_TIMEOUT)) begin
            bit_cnt <= 4'd0;
            shift   <= 8'h00;
         end
      end
   end

   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_data   = ram_data_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.frame_done = frame_done_q;
   assign bus.gap_err    = gap_err_q;
endmodule

// File: tb/tb_ram_writer_serial.sv
// Self-checking bench: a default-depth and a DEPTH=4 receiver share one serial
// link; a queue-based reference model predicts every RAM write and gap error.
module tb_ram_writer_serial;
   localparam int ADDR_W       = 16;
   localparam int DEPTH        = 8192;
   localparam int DEPTH_S      = 4;
   localparam int IDLE_TIMEOUT = 4096;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              fd;
      int                cyc;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic sclk  = 1'b0;
   logic sda   = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   int   ptr_main = 0;
   int   ptr_small = 0;
   int   last_fall = 0;
   int   gap_main = 0;
   int   gap_small = 0;
   int   exp_gaps = 0;
   int   stray_fd = 0;
   wr_t  wr_main[$];
   wr_t  wr_small[$];
   wr_t  exp_main[$];
   wr_t  exp_small[$];

   ram_writer_serial_if #(.ADDR_W(ADDR_W)) bus_main ();
   ram_writer_serial_if #(.ADDR_W(ADDR_W)) bus_small ();

   assign bus_main.sclk  = sclk;
   assign bus_main.sda   = sda;
   assign bus_small.sclk = sclk;
   assign bus_small.sda  = sda;

   ram_writer_serial #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut_main (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_main.slave)
   );

   ram_writer_serial #(.ADDR_W(ADDR_W), .DEPTH(DEPTH_S), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_small.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every RAM write and gap pulse away from the active edge
   always @(negedge clk) begin
      if (bus_main.ram_we)
         wr_main.push_back('{bus_main.ram_addr, bus_main.ram_data, bus_main.frame_done, cyc});
      if (bus_small.ram_we)
         wr_small.push_back('{bus_small.ram_addr, bus_small.ram_data, bus_small.frame_done, cyc});
      if (bus_main.gap_err) gap_main++;
      if (bus_small.gap_err) gap_small++;
      if ((bus_main.frame_done && !bus_main.ram_we) || (bus_small.frame_done && !bus_small.ram_we))
         stray_fd++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_scoreboard();
      wr_main.delete();
      wr_small.delete();
      exp_main.delete();
      exp_small.delete();
      gap_main  = 0;
      gap_small = 0;
      exp_gaps  = 0;
      stray_fd  = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sclk  = 1'b0;
      sda   = 1'b0;
      wait_clk(4);
      reset = 1'b1;
      wait_clk(2);
      ptr_main  = 0;
      ptr_small = 0;
   endtask

   task automatic send_slot(input logic b, input int hi, input int lo);
      sda  = b;
      sclk = 1'b1;
      wait_clk(hi);
      sclk      = 1'b0;
      last_fall = cyc;
      wait_clk(lo);
   endtask

   task automatic send_bits(input logic [7:0] d, input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) send_slot(d[i], hi, lo);
   endtask

   // Reference model: a byte with a clean gap lands at the next address
   // (modulo depth), 4 clk after the gap-slot falling edge.
   task automatic send_byte(input logic [7:0] d, input logic gap, input int hi, input int lo);
      send_bits(d, 8, hi, lo);
      send_slot(gap, hi, lo);
      if (!gap) begin
         exp_main.push_back('{ADDR_W'(ptr_main), d, (ptr_main == DEPTH - 1), last_fall + 4});
         exp_small.push_back('{ADDR_W'(ptr_small), d, (ptr_small == DEPTH_S - 1), last_fall + 4});
         ptr_main  = (ptr_main + 1) % DEPTH;
         ptr_small = (ptr_small + 1) % DEPTH_S;
      end else begin
         exp_gaps++;
      end
   endtask

   task automatic test_reset();
      clear_scoreboard();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sclk = ~sclk;
         sda  = ~sda;
         wait_clk(4);
         checks++;
         if (bus_main.ram_addr !== '0 || bus_main.ram_data !== 8'h00 || bus_main.ram_we !== 1'b0 ||
             bus_main.frame_done !== 1'b0 || bus_main.gap_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got addr=%0h data=%02h we=%0b fd=%0b gap=%0b, expected all 0",
                     bus_main.ram_addr, bus_main.ram_data, bus_main.ram_we, bus_main.frame_done, bus_main.gap_err);
         end
      end
      checks++;
      if (wr_main.size() != 0 || wr_small.size() != 0) begin
         errors++;
         $display("[TB] FAIL reset_no_write: got %0d writes, expected 0", wr_main.size() + wr_small.size());
      end
      sda   = 1'b0;
      reset = 1'b1;
      wait_clk(2);
      ptr_main  = 0;
      ptr_small = 0;
      send_byte(8'h5A, 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_main.size() != 1 || wr_main[0].addr !== '0 || wr_main[0].data !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL reset_first_addr: got %0d writes addr=%0h data=%02h, expected 1 write addr=0 data=5a",
                  wr_main.size(), wr_main[0].addr, wr_main[0].data);
      end
   endtask

   task automatic test_basic_bytes();
      do_reset();
      clear_scoreboard();
      send_byte(8'hA5, 1'b0, 8, 8);
      send_byte(8'h3C, 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_main.size() != exp_main.size()) begin
         errors++;
         $display("[TB] FAIL basic_count: got %0d writes, expected %0d", wr_main.size(), exp_main.size());
      end
      for (int i = 0; i < exp_main.size() && i < wr_main.size(); i++) begin
         checks++;
         if (wr_main[i].addr !== exp_main[i].addr || wr_main[i].data !== exp_main[i].data ||
             wr_main[i].fd !== exp_main[i].fd || wr_main[i].cyc != exp_main[i].cyc) begin
            errors++;
            $display("[TB] FAIL basic_write%0d: got addr=%0h data=%02h fd=%0b cyc=%0d, expected addr=%0h data=%02h fd=%0b cyc=%0d",
                     i, wr_main[i].addr, wr_main[i].data, wr_main[i].fd, wr_main[i].cyc,
                     exp_main[i].addr, exp_main[i].data, exp_main[i].fd, exp_main[i].cyc);
         end
      end
   endtask

   task automatic test_gap_error();
      clear_scoreboard();
      send_byte(8'h55, 1'b1, 8, 8);
      wait_clk(6);
      checks++;
      if (gap_main != 1 || wr_main.size() != 0) begin
         errors++;
         $display("[TB] FAIL gap_reject: got gap_cycles=%0d writes=%0d, expected gap_cycles=1 writes=0",
                  gap_main, wr_main.size());
      end
      send_byte(8'h0F, 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_main.size() != 1 || wr_main[0].addr !== exp_main[0].addr || wr_main[0].data !== 8'h0F) begin
         errors++;
         $display("[TB] FAIL gap_next_byte: got %0d writes addr=%0h data=%02h, expected 1 write addr=%0h data=0f",
                  wr_main.size(), wr_main[0].addr, wr_main[0].data, exp_main[0].addr);
      end
   endtask

   task automatic test_idle_timeout();
      clear_scoreboard();
      send_bits(8'h07, 3, 8, 8);
      wait_clk(IDLE_TIMEOUT + 10);
      send_byte(8'h81, 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_main.size() != 1 || wr_main[0].addr !== exp_main[0].addr || wr_main[0].data !== 8'h81) begin
         errors++;
         $display("[TB] FAIL idle_realign: got %0d writes addr=%0h data=%02h, expected 1 write addr=%0h data=81",
                  wr_main.size(), wr_main[0].addr, wr_main[0].data, exp_main[0].addr);
      end
      checks++;
      if (gap_main != 0) begin
         errors++;
         $display("[TB] FAIL idle_no_gap: got gap_cycles=%0d, expected 0", gap_main);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      clear_scoreboard();
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_small.size() != 5) begin
         errors++;
         $display("[TB] FAIL wrap_count: got %0d writes, expected 5", wr_small.size());
      end
      for (int i = 0; i < 5 && i < wr_small.size(); i++) begin
         checks++;
         if (wr_small[i].addr !== ADDR_W'(i % DEPTH_S) || wr_small[i].data !== 8'(i + 1) ||
             wr_small[i].fd !== (i == 3)) begin
            errors++;
            $display("[TB] FAIL wrap_write%0d: got addr=%0h data=%02h fd=%0b, expected addr=%0h data=%02h fd=%0b",
                     i, wr_small[i].addr, wr_small[i].data, wr_small[i].fd, i % DEPTH_S, i + 1, (i == 3));
         end
      end
      checks++;
      if (stray_fd != 0) begin
         errors++;
         $display("[TB] FAIL wrap_stray_fd: got %0d frame_done cycles without ram_we, expected 0", stray_fd);
      end
   endtask

   task automatic test_reset_mid_byte();
      clear_scoreboard();
      send_bits(8'h00, 5, 8, 8);
      reset = 1'b0;
      wait_clk(5);
      reset = 1'b1;
      wait_clk(2);
      ptr_main  = 0;
      ptr_small = 0;
      send_byte(8'hFF, 1'b0, 8, 8);
      wait_clk(6);
      checks++;
      if (wr_main.size() != 1 || wr_main[0].addr !== '0 || wr_main[0].data !== 8'hFF || gap_main != 0) begin
         errors++;
         $display("[TB] FAIL reset_mid_byte: got %0d writes addr=%0h data=%02h gap=%0d, expected 1 write addr=0 data=ff gap=0",
                  wr_main.size(), wr_main[0].addr, wr_main[0].data, gap_main);
      end
   endtask

   task automatic test_random();
      clear_scoreboard();
      for (int n = 0; n < 20; n++) begin
         send_byte(8'($urandom), ($urandom_range(4, 0) == 0), $urandom_range(12, 4), $urandom_range(12, 4));
      end
      wait_clk(8);
      checks++;
      if (wr_main.size() != exp_main.size() || wr_small.size() != exp_small.size() ||
          gap_main != exp_gaps || gap_small != exp_gaps) begin
         errors++;
         $display("[TB] FAIL random_counts: got writes=%0d/%0d gaps=%0d/%0d, expected writes=%0d/%0d gaps=%0d",
                  wr_main.size(), wr_small.size(), gap_main, gap_small, exp_main.size(), exp_small.size(), exp_gaps);
      end
      for (int i = 0; i < exp_main.size() && i < wr_main.size() && i < wr_small.size(); i++) begin
         checks++;
         if (wr_main[i].addr !== exp_main[i].addr || wr_main[i].data !== exp_main[i].data ||
             wr_main[i].cyc != exp_main[i].cyc || wr_small[i].addr !== exp_small[i].addr ||
             wr_small[i].data !== exp_small[i].data || wr_small[i].fd !== exp_small[i].fd) begin
            errors++;
            $display("[TB] FAIL random_write%0d: got addr=%0h/%0h data=%02h/%02h fd4=%0b cyc=%0d, expected addr=%0h/%0h data=%02h fd4=%0b cyc=%0d",
                     i, wr_main[i].addr, wr_small[i].addr, wr_main[i].data, wr_small[i].data, wr_small[i].fd,
                     wr_main[i].cyc, exp_main[i].addr, exp_small[i].addr, exp_main[i].data, exp_small[i].fd,
                     exp_main[i].cyc);
         end
      end
   endtask

   initial begin
      wait_clk(1);
      test_reset();
      test_basic_bytes();
      test_gap_error();
      test_idle_timeout();
      test_wrap();
      test_reset_mid_byte();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
